// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide, one iteration per clock.
module muldiv_unit #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [Width-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] hi_o,
    output logic [Width-1:0] lo_o
);

    localparam int CntW = $clog2(Width) + 1;
    localparam logic [CntW-1:0] LastIter = CntW'(Width - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [CntW-1:0]  cnt_reg;
    logic             is_div_reg;
    logic             res_neg_reg;
    logic             rem_neg_reg;
    logic             div_zero_reg;
    logic [Width-1:0] a_raw_reg;
    logic [Width-1:0] mcand_reg;
    logic [Width-1:0] acc_hi_reg;
    logic [Width-1:0] acc_lo_reg;
    logic [Width-1:0] hi_reg;
    logic [Width-1:0] lo_reg;
    logic             busy_reg;
    logic             done_reg;

    // Operand magnitudes and result signs, decoded at the start edge
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [Width-1:0] a_mag;
    logic [Width-1:0] b_mag;

    always_comb begin
        signed_op = ~op_i[0];
        a_neg     = signed_op & a_i[Width-1];
        b_neg     = signed_op & b_i[Width-1];
        a_mag     = a_neg ? -a_i : a_i;
        b_mag     = b_neg ? -b_i : b_i;
    end

    // One multiply step: conditional add into the upper half, then shift right
    logic [Width:0]   mul_sum;
    logic [Width-1:0] mul_hi_next;
    logic [Width-1:0] mul_lo_next;

    always_comb begin
        mul_sum = {1'b0, acc_hi_reg};
        if (acc_lo_reg[0]) begin
            mul_sum = {1'b0, acc_hi_reg} + {1'b0, mcand_reg};
        end
        mul_hi_next = mul_sum[Width:1];
        mul_lo_next = {mul_sum[0], acc_lo_reg[Width-1:1]};
    end

    // One restoring-divide step: remainder in acc_hi, quotient shifts into acc_lo
    logic [Width:0]   div_shift;
    logic [Width:0]   div_diff;
    logic [Width-1:0] div_rem_next;
    logic [Width-1:0] div_quo_next;

    always_comb begin
        div_shift = {acc_hi_reg, acc_lo_reg[Width-1]};
        div_diff  = div_shift - {1'b0, mcand_reg};
        if (!div_diff[Width]) begin
            div_rem_next = div_diff[Width-1:0];
            div_quo_next = {acc_lo_reg[Width-2:0], 1'b1};
        end else begin
            div_rem_next = div_shift[Width-1:0];
            div_quo_next = {acc_lo_reg[Width-2:0], 1'b0};
        end
    end

    // Sign correction and divide-by-zero override applied when leaving FIN
    logic [2*Width-1:0] prod_fix;
    logic [Width-1:0]   res_hi;
    logic [Width-1:0]   res_lo;

    always_comb begin
        prod_fix = res_neg_reg ? -{acc_hi_reg, acc_lo_reg} : {acc_hi_reg, acc_lo_reg};
        res_hi   = prod_fix[2*Width-1:Width];
        res_lo   = prod_fix[Width-1:0];
        if (is_div_reg) begin
            if (div_zero_reg) begin
                res_hi = a_raw_reg;
                res_lo = '1;
            end else begin
                res_hi = rem_neg_reg ? -acc_hi_reg : acc_hi_reg;
                res_lo = res_neg_reg ? -acc_lo_reg : acc_lo_reg;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_i) state_next = CALC;
            CALC:    if (cnt_reg == LastIter) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg      <= '0;
            is_div_reg   <= 1'b0;
            res_neg_reg  <= 1'b0;
            rem_neg_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
            a_raw_reg    <= '0;
            mcand_reg    <= '0;
            acc_hi_reg   <= '0;
            acc_lo_reg   <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            busy_reg <= (state_next != IDLE);
            done_reg <= (state_reg == FIN);
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (hi_we_i) hi_reg <= wdata_i;
                    if (lo_we_i) lo_reg <= wdata_i;
                    if (start_i) begin
                        is_div_reg   <= op_i[1];
                        res_neg_reg  <= a_neg ^ b_neg;
                        rem_neg_reg  <= a_neg;
                        div_zero_reg <= (b_i == '0);
                        a_raw_reg    <= a_i;
                        acc_hi_reg   <= '0;
                        if (op_i[1]) begin
                            mcand_reg  <= b_mag;
                            acc_lo_reg <= a_mag;
                        end else begin
                            mcand_reg  <= a_mag;
                            acc_lo_reg <= b_mag;
                        end
                    end
                end
                CALC: begin
                    cnt_reg <= cnt_reg + CntW'(1);
                    if (is_div_reg) begin
                        acc_hi_reg <= div_rem_next;
                        acc_lo_reg <= div_quo_next;
                    end else begin
                        acc_hi_reg <= mul_hi_next;
                        acc_lo_reg <= mul_lo_next;
                    end
                end
                FIN: begin
                    hi_reg <= res_hi;
                    lo_reg <= res_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy_o = busy_reg;
    assign done_o = done_reg;
    assign hi_o   = hi_reg;
    assign lo_o   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: 32-bit and 8-bit instances, hand-computed results.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start32 = 1'b0;
    logic [1:0]  op32    = 2'b00;
    logic [31:0] a32     = '0;
    logic [31:0] b32     = '0;
    logic        hi_we32 = 1'b0;
    logic        lo_we32 = 1'b0;
    logic [31:0] wdata32 = '0;
    logic        busy32;
    logic        done32;
    logic [31:0] hi32;
    logic [31:0] lo32;

    logic       start8 = 1'b0;
    logic [1:0] op8    = 2'b00;
    logic [7:0] a8     = '0;
    logic [7:0] b8     = '0;
    logic       busy8;
    logic       done8;
    logic [7:0] hi8;
    logic [7:0] lo8;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.Width(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .start_i(start32), .op_i(op32),
        .a_i(a32), .b_i(b32), .hi_we_i(hi_we32), .lo_we_i(lo_we32),
        .wdata_i(wdata32), .busy_o(busy32), .done_o(done32),
        .hi_o(hi32), .lo_o(lo32)
    );

    muldiv_unit #(.Width(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .op_i(op8),
        .a_i(a8), .b_i(b8), .hi_we_i(1'b0), .lo_we_i(1'b0),
        .wdata_i(8'h00), .busy_o(busy8), .done_o(done8),
        .hi_o(hi8), .lo_o(lo8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a falling edge; start is sampled on the next rising edge (E0)
    task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        @(negedge clk);
        start32 = 1'b0; a32 = 32'h5A5A5A5A; b32 = 32'hA5A5A5A5;
    endtask

    // Counts edges after E0 until done; optionally pulses start+lo_we at cycle inject
    task automatic wait32(input int inject, output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        while (!done32 && lat < 100) begin
            if (busy32) bcnt++;
            if (lat == inject) begin
                start32 = 1'b1; op32 = 2'b11; a32 = 32'd9; b32 = 32'd0;
                lo_we32 = 1'b1; wdata32 = 32'h0000DEAD;
            end
            @(negedge clk);
            start32 = 1'b0; lo_we32 = 1'b0;
            lat++;
        end
    endtask

    task automatic run32(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int inject);
        int lat, bcnt;
        issue32(op, a, b);
        wait32(inject, lat, bcnt);
        $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h latency=%0d busy=%0d",
                 tag, op, a, b, hi32, lo32, lat, bcnt);
        check({tag, " hi"}, 64'(hi32), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo32), 64'(exp_lo));
        check({tag, " latency"}, 64'(lat), 64'd33);
        check({tag, " busy cycles"}, 64'(bcnt), 64'd33);
    endtask

    task automatic run8(input string tag, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_hi, input logic [7:0] exp_lo);
        int lat;
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'h3C; b8 = 8'hC3;
        lat = 0;
        while (!done8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h latency=%0d", tag, op, a, b, hi8, lo8, lat);
        check({tag, " hi"}, 64'(hi8), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo8), 64'(exp_lo));
        check({tag, " latency"}, 64'(lat), 64'd9);
    endtask

    initial begin
        int seen;

        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy32), 64'd0);
        check("reset done", 64'(done32), 64'd0);
        check("reset hi", 64'(hi32), 64'd0);
        check("reset lo", 64'(lo32), 64'd0);
        rst = 1'b0;

        run32("multu max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, -1);
        run32("mult -3x5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, -1);
        run32("mult minxmin", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, -1);
        run32("div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, -1);
        run32("divu 7/2", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, -1);
        run32("div 7/-2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, -1);
        run32("divu by zero", 2'b11, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, -1);
        run32("div by zero", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, -1);
        run32("div min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, -1);

        // MTHI in IDLE, issued in the cycle done is high
        hi_we32 = 1'b1; wdata32 = 32'hAAAA5555;
        @(negedge clk);
        hi_we32 = 1'b0;
        $display("mthi wdata=%h -> hi=%h lo=%h done=%0d", 32'hAAAA5555, hi32, lo32, done32);
        check("mthi hi", 64'(hi32), 64'hAAAA5555);
        check("mthi lo held", 64'(lo32), 64'h80000000);
        check("mthi no done", 64'(done32), 64'd0);
        check("mthi not busy", 64'(busy32), 64'd0);

        run32("multu mid-calc pulses", 2'b01, 32'h10, 32'h10, 32'h0, 32'h100, 5);
        @(negedge clk);
        check("ignored start not queued", 64'(busy32), 64'd0);
        check("no extra done", 64'(done32), 64'd0);

        issue32(2'b01, 32'h0000FFFF, 32'h0000FFFF);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        $display("reset mid-calc -> busy=%0d done=%0d hi=%h lo=%h", busy32, done32, hi32, lo32);
        check("abort busy", 64'(busy32), 64'd0);
        check("abort done", 64'(done32), 64'd0);
        check("abort hi", 64'(hi32), 64'd0);
        check("abort lo", 64'(lo32), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) seen++;
        end
        check("abort no done", 64'(seen), 64'd0);
        run32("multu after reset", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, -1);

        run8("w8 multu max", 2'b01, 8'hFF, 8'hFF, 8'hFE, 8'h01);
        run8("w8 div min/3", 2'b10, 8'h80, 8'h03, 8'hFE, 8'hD6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
